// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_pkg
// Purpose  : Shared types and helpers for the writable waveform table.
//            Holds the loader state encoding and the table-depth helper.
// Revision : 1.0 - initial release
// ============================================================================
package wave_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Number of table entries addressed by an address of the given width
    function automatic int depth_of(input int address_width);
        return 1 << address_width;
    endfunction

endpackage : wave_pkg
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram
// Purpose  : Table storage with one write port and two independent
//            registered read ports. A read to the address being written in
//            the same cycle returns the previous contents.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram
    import wave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr1,
    input  logic [ADDRESS_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic [DATA_WIDTH-1:0]    rdata2
);

    localparam int c_DEPTH = depth_of(ADDRESS_WIDTH);

    // Array is deliberately left without reset so it maps onto block RAM
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [DATA_WIDTH-1:0] r_rdata2;

    // Write port; non-blocking update gives read-old behaviour on collision
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Both read ports sample the array every cycle, independent of writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            r_rdata1 <= r_mem[raddr1];
            r_rdata2 <= r_mem[raddr2];
        end
    end

    assign rdata1 = r_rdata1;
    assign rdata2 = r_rdata2;

endmodule : dp_ram
`default_nettype wire

// File: rtl/wave_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : wave_ram_loader
// Purpose  : Writable waveform table. A load accepts exactly one full table
//            of samples over a valid/ready stream, writing ascending
//            addresses; two read ports serve the phase counters with one
//            cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module wave_ram_loader
    import wave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     din_valid,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic                     din_ready,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [ADDRESS_WIDTH-1:0] addr2,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [DATA_WIDTH-1:0]    dout2,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   wr_count
);

    localparam int                     c_DEPTH     = depth_of(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(c_DEPTH - 1);

    loader_state_t              r_state;
    logic [ADDRESS_WIDTH-1:0]   r_wr_addr;
    logic [ADDRESS_WIDTH:0]     r_wr_count;
    logic                       r_din_ready;
    logic                       r_busy;
    logic                       r_done;
    logic                       w_wr_en;

    // A transfer happens only when the registered ready meets valid
    assign w_wr_en = din_valid & r_din_ready;

    // Load sequencer: state, write pointer, count and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_addr   <= '0;
            r_wr_count  <= '0;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= LOAD;
                        r_wr_addr   <= '0;
                        r_wr_count  <= '0;
                        r_done      <= 1'b0;
                        r_din_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    // start is ignored here; only accepted samples advance
                    if (w_wr_en) begin
                        r_wr_addr  <= r_wr_addr + 1'b1;
                        r_wr_count <= r_wr_count + 1'b1;
                        if (r_wr_addr == c_LAST_ADDR) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_din_ready <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_din_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    dp_ram #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_dp_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (w_wr_en),
        .waddr  (r_wr_addr),
        .wdata  (din),
        .raddr1 (addr),
        .raddr2 (addr2),
        .rdata1 (dout),
        .rdata2 (dout2)
    );

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_count  = r_wr_count;

endmodule : wave_ram_loader
`default_nettype wire
